// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the cpu trace recorder: state encoding, entry kinds
// and the layout of a stored trace entry {stamp, kind, index, data}.
package cpu_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FROZEN  = 2'd2
   } trace_state_e;

   localparam logic KIND_REG = 1'b0;
   localparam logic KIND_MEM = 1'b1;

   // Total entry width: stamp + kind bit + index field + data.
   function automatic int entry_w(input int cnt_w, input int idx_w, input int width);
      return cnt_w + 1 + idx_w + width;
   endfunction

   // Field offsets inside an entry, data occupying the low bits.
   function automatic int idx_lsb(input int width);
      return width;
   endfunction

   function automatic int kind_lsb(input int idx_w, input int width);
      return width + idx_w;
   endfunction

   function automatic int stamp_lsb(input int idx_w, input int width);
      return width + idx_w + 1;
   endfunction

endpackage

// File: rtl/trace_ring.sv
// Ring storage for trace entries: up to two writes per cycle at wr_ptr and
// wr_ptr+1, a single head read, and the occupancy count. In stop-when-full
// mode excess writes are refused; in wrap mode they push out the oldest.
module trace_ring #(
   parameter int EW    = 53,
   parameter int DEPTH = 16,
   parameter int WRAP  = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    wr0_en,
   input  logic [EW-1:0]           wr0_data,
   input  logic                    wr1_en,
   input  logic [EW-1:0]           wr1_data,
   input  logic                    rd_en,
   output logic [EW-1:0]           rd_head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    n_wr, n_keep;
   logic [CW:0]   total;
   logic          keep0, keep1;

   // Decide which writes land, and advance pointers/count accordingly.
   always_comb begin
      n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
      total    = {1'b0, count_q} + (CW+1)'(n_wr);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop     = 1'b0;
      keep0    = wr0_en;
      keep1    = wr1_en;
      n_keep   = n_wr;
      if (WRAP == 0) begin
         // The first write of a pair takes the last free slot if only one is left.
         keep0    = wr0_en && (count_q != FULL);
         keep1    = wr1_en && (total <= {1'b0, FULL});
         n_keep   = {1'b0, keep0} + {1'b0, keep1};
         drop     = (wr0_en && !keep0) || (wr1_en && !keep1);
         wr_ptr_d = wr_ptr_q + PW'(n_keep);
         count_d  = count_q + CW'(n_keep);
      end else begin
         wr_ptr_d = wr_ptr_q + PW'(n_wr);
         if (total > {1'b0, FULL}) begin
            // Overwritten entries were the oldest, so the head moves past them.
            drop     = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(total - {1'b0, FULL});
            count_d  = FULL;
         end else begin
            count_d  = total[CW-1:0];
         end
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_d + PW'(1);
         count_d  = count_d - CW'(1);
      end
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Entry storage; contents are meaningless outside [rd_ptr, rd_ptr+count).
   always_ff @(posedge clk) begin
      if (keep0) mem[wr_ptr_q] <= wr0_data;
      if (keep1) mem[wr_ptr_q + PW'(1)] <= wr1_data;
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_head = mem[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Debug trace recorder: timestamps register-file and data-memory writes into
// a ring buffer while capturing, then streams entries oldest-first once frozen.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int RNUM_W      = 2,
   parameter int AW          = 2,
   parameter int IDX_W       = 4,
   parameter int CNT_W       = 16,
   parameter int DEPTH       = 16,
   parameter int WRAP        = 0,
   parameter int CYCLE_LIMIT = 14
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              arm,
   input  logic                              freeze,
   input  logic                              clear,
   input  logic                              reg_we,
   input  logic [RNUM_W-1:0]                 reg_wnum,
   input  logic [WIDTH-1:0]                  reg_wdata,
   input  logic                              mem_we,
   input  logic [AW-1:0]                     mem_addr,
   input  logic [WIDTH-1:0]                  mem_wdata,
   output logic                              rd_valid,
   input  logic                              rd_ready,
   output logic [CNT_W+1+IDX_W+WIDTH-1:0]    rd_data,
   output logic                              rd_last,
   output logic [$clog2(DEPTH):0]            count,
   output logic [1:0]                        state,
   output logic                              lost,
   output logic                              limit_hit
);

   localparam int EW = entry_w(CNT_W, IDX_W, WIDTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STAMP = (CYCLE_LIMIT == 0) ? '0 : CNT_W'(CYCLE_LIMIT - 1);

   trace_state_e     state_q, state_d;
   logic [CNT_W-1:0] stamp_q, stamp_d;
   logic             lost_q, lost_d, limit_hit_q, limit_hit_d;
   logic             capturing, wr0_en, wr1_en, rd_en, ring_drop;
   logic [EW-1:0]    reg_entry, mem_entry, wr0_data, rd_head;

   // Entry packing; when only one strobe fires it always uses the first port.
   always_comb begin
      reg_entry = {stamp_q, KIND_REG, IDX_W'(reg_wnum), reg_wdata};
      mem_entry = {stamp_q, KIND_MEM, IDX_W'(mem_addr), mem_wdata};
      capturing = (state_q == ST_CAPTURE) && !clear;
      wr0_en    = capturing && (reg_we || mem_we);
      wr0_data  = reg_we ? reg_entry : mem_entry;
      wr1_en    = capturing && reg_we && mem_we;
      rd_valid  = (state_q == ST_FROZEN) && (count != '0);
      rd_en     = rd_valid && rd_ready && !clear;
      rd_last   = rd_valid && (count == CW'(1));
      rd_data   = rd_valid ? rd_head : '0;
   end

   trace_ring #(
      .EW    (EW),
      .DEPTH (DEPTH),
      .WRAP  (WRAP)
   ) u_ring (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .wr0_en   (wr0_en),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_data (mem_entry),
      .rd_en    (rd_en),
      .rd_head  (rd_head),
      .count    (count),
      .drop     (ring_drop)
   );

   // Next-state logic: capture control, stamp counter and sticky flags.
   always_comb begin
      state_d     = state_q;
      stamp_d     = stamp_q;
      lost_d      = lost_q;
      limit_hit_d = limit_hit_q;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_CAPTURE;
               stamp_d = '0;
            end
         end
         ST_CAPTURE: begin
            if (stamp_q != '1) stamp_d = stamp_q + CNT_W'(1);
            if (ring_drop) lost_d = 1'b1;
            // The limit wins over a simultaneous freeze so limit_hit is recorded.
            if ((CYCLE_LIMIT != 0) && (stamp_q == LAST_STAMP)) begin
               state_d     = ST_FROZEN;
               limit_hit_d = 1'b1;
            end else if (freeze) begin
               state_d = ST_FROZEN;
            end
         end
         ST_FROZEN: begin
            state_d = ST_FROZEN;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear) begin
         state_d     = ST_IDLE;
         stamp_d     = '0;
         lost_d      = 1'b0;
         limit_hit_d = 1'b0;
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         stamp_q     <= '0;
         lost_q      <= 1'b0;
         limit_hit_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stamp_q     <= stamp_d;
         lost_q      <= lost_d;
         limit_hit_q <= limit_hit_d;
      end
   end

   assign state     = state_q;
   assign lost      = lost_q;
   assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: three configurations share one stimulus stream
// (depth 16 stop/limit 14, depth 4 stop, depth 4 wrap) and are checked against
// a queue-style model plus directed scenarios with hand-derived expectations.
module tb_cpu_trace_buffer;

   localparam int EW = 53;
   localparam int NI = 3;
   typedef logic [EW-1:0] ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        arm = 1'b0, freeze = 1'b0, clear = 1'b0;
   logic        reg_we = 1'b0, mem_we = 1'b0, rd_ready = 1'b0;
   logic [1:0]  reg_wnum = '0, mem_addr = '0;
   logic [31:0] reg_wdata = '0, mem_wdata = '0;

   logic [2:0]          vld_o, last_o, lost_o, lim_o;
   logic [2:0][1:0]     st_o;
   logic [2:0][EW-1:0]  dat_o;
   logic [4:0]          cnt0;
   logic [2:0]          cnt1, cnt2;

   int errors = 0;
   int checks = 0;

   // Model: per-instance oldest-first entry list and flags.
   ent_t mbuf [NI][16];
   int   mcnt [NI];
   int   mst [NI];
   int   mstamp [NI];
   bit   mlost [NI];
   bit   mlim [NI];

   always #5 clk = ~clk;

   cpu_trace_buffer #(.DEPTH(16), .WRAP(0), .CYCLE_LIMIT(14)) dut0 (
      .clk(clk), .rst(rst), .arm(arm), .freeze(freeze), .clear(clear),
      .reg_we(reg_we), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rd_valid(vld_o[0]), .rd_ready(rd_ready), .rd_data(dat_o[0]), .rd_last(last_o[0]),
      .count(cnt0), .state(st_o[0]), .lost(lost_o[0]), .limit_hit(lim_o[0]));

   cpu_trace_buffer #(.DEPTH(4), .WRAP(0), .CYCLE_LIMIT(0)) dut1 (
      .clk(clk), .rst(rst), .arm(arm), .freeze(freeze), .clear(clear),
      .reg_we(reg_we), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rd_valid(vld_o[1]), .rd_ready(rd_ready), .rd_data(dat_o[1]), .rd_last(last_o[1]),
      .count(cnt1), .state(st_o[1]), .lost(lost_o[1]), .limit_hit(lim_o[1]));

   cpu_trace_buffer #(.DEPTH(4), .WRAP(1), .CYCLE_LIMIT(0)) dut2 (
      .clk(clk), .rst(rst), .arm(arm), .freeze(freeze), .clear(clear),
      .reg_we(reg_we), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rd_valid(vld_o[2]), .rd_ready(rd_ready), .rd_data(dat_o[2]), .rd_last(last_o[2]),
      .count(cnt2), .state(st_o[2]), .lost(lost_o[2]), .limit_hit(lim_o[2]));

   function automatic int m_depth(input int i);
      return (i == 0) ? 16 : 4;
   endfunction

   function automatic bit m_wrap(input int i);
      return (i == 2);
   endfunction

   function automatic int m_limit(input int i);
      return (i == 0) ? 14 : 0;
   endfunction

   function automatic int got_cnt(input int i);
      if (i == 0) return int'(cnt0);
      if (i == 1) return int'(cnt1);
      return int'(cnt2);
   endfunction

   function automatic ent_t make_entry(input int stamp, input bit kind, input logic [3:0] idx,
                                       input logic [31:0] data);
      ent_t e;
      e = {16'(stamp), kind, idx, data};
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mcnt[i] = 0; mst[i] = 0; mstamp[i] = 0; mlost[i] = 0; mlim[i] = 0;
      end
   endtask

   task automatic model_pop(input int i);
      for (int k = 0; k < 15; k++) mbuf[i][k] = mbuf[i][k+1];
      mcnt[i]--;
   endtask

   task automatic model_push(input int i, input ent_t e);
      if (mcnt[i] < m_depth(i)) begin
         mbuf[i][mcnt[i]] = e;
         mcnt[i]++;
      end else begin
         mlost[i] = 1'b1;
         if (m_wrap(i)) begin
            model_pop(i);
            mbuf[i][mcnt[i]] = e;
            mcnt[i]++;
         end
      end
   endtask

   // One rising edge of the recorder, from the behavioural rules.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         if (clear) begin
            mst[i] = 0; mcnt[i] = 0; mlost[i] = 0; mlim[i] = 0; mstamp[i] = 0;
         end else if (mst[i] == 0) begin
            if (arm) begin mst[i] = 1; mstamp[i] = 0; end
         end else if (mst[i] == 1) begin
            if (reg_we) model_push(i, make_entry(mstamp[i], 1'b0, {2'b00, reg_wnum}, reg_wdata));
            if (mem_we) model_push(i, make_entry(mstamp[i], 1'b1, {2'b00, mem_addr}, mem_wdata));
            if (m_limit(i) != 0 && mstamp[i] == m_limit(i) - 1) begin
               mst[i] = 2; mlim[i] = 1'b1;
            end else if (freeze) begin
               mst[i] = 2;
            end
            if (mstamp[i] < 65535) mstamp[i]++;
         end else begin
            if (mcnt[i] > 0 && rd_ready) model_pop(i);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      arm = 0; freeze = 0; clear = 0; reg_we = 0; mem_we = 0; rd_ready = 0;
   endtask

   task automatic do_clear_arm();
      idle_inputs();
      clear = 1; step(); clear = 0;
      arm = 1; step(); arm = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (st_o[i] !== 2'd0 || got_cnt(i) != 0 || vld_o[i] !== 1'b0 || last_o[i] !== 1'b0 ||
             dat_o[i] !== '0 || lost_o[i] !== 1'b0 || lim_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_values inst%0d: state=%0d count=%0d valid=%b last=%b data=%h lost=%b lim=%b, need all zero",
                     i, st_o[i], got_cnt(i), vld_o[i], last_o[i], dat_o[i], lost_o[i], lim_o[i]);
         end
      end
      rst = 1;
      // Reset in the middle of a capture must act before the next edge.
      arm = 1; step(); arm = 0;
      reg_we = 1;
      for (int k = 0; k < 3; k++) begin
         reg_wnum = 2'(k); reg_wdata = $urandom; step();
      end
      reg_we = 0;
      checks++;
      if (cnt0 !== 5'd3) begin
         errors++; $display("FAIL pre_reset_count: got %0d need 3", cnt0);
      end
      #2 rst = 0;
      #1;
      model_reset();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (st_o[i] !== 2'd0 || got_cnt(i) != 0 || vld_o[i] !== 1'b0 || lost_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset inst%0d: state=%0d count=%0d valid=%b lost=%b, need 0 0 0 0",
                     i, st_o[i], got_cnt(i), vld_o[i], lost_o[i]);
         end
      end
      #1 rst = 1;
      $display("txn reset checks done");
   endtask

   task automatic test_basic();
      ent_t exp0, exp1;
      exp0 = make_entry(0, 1'b0, 4'd1, 32'd5);
      exp1 = make_entry(2, 1'b0, 4'd2, 32'd7);
      do_clear_arm();
      reg_we = 1; reg_wnum = 2'd1; reg_wdata = 32'd5; step();  // stamp 0
      reg_we = 0; step();                                       // stamp 1
      reg_we = 1; reg_wnum = 2'd2; reg_wdata = 32'd7; step();  // stamp 2
      reg_we = 0; freeze = 1; step();                          // stamp 3
      freeze = 0;
      // Strobes and arm while frozen must not change anything.
      reg_we = 1; mem_we = 1; arm = 1; step();
      idle_inputs();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (st_o[i] !== 2'd2 || got_cnt(i) != 2) begin
            errors++; $display("FAIL basic_frozen inst%0d: state=%0d count=%0d need 2 2", i, st_o[i], got_cnt(i));
         end
         checks++;
         if (vld_o[i] !== 1'b1 || dat_o[i] !== exp0 || last_o[i] !== 1'b0) begin
            errors++; $display("FAIL basic_first inst%0d: valid=%b data=%h last=%b need 1 %h 0", i, vld_o[i], dat_o[i], last_o[i], exp0);
         end
      end
      rd_ready = 1; step();
      $display("txn basic read %h", dat_o[0]);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (vld_o[i] !== 1'b1 || dat_o[i] !== exp1 || last_o[i] !== 1'b1) begin
            errors++; $display("FAIL basic_second inst%0d: valid=%b data=%h last=%b need 1 %h 1", i, vld_o[i], dat_o[i], last_o[i], exp1);
         end
      end
      step();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (vld_o[i] !== 1'b0 || st_o[i] !== 2'd2 || dat_o[i] !== '0) begin
            errors++; $display("FAIL basic_drained inst%0d: valid=%b state=%0d data=%h need 0 2 0", i, vld_o[i], st_o[i], dat_o[i]);
         end
      end
      rd_ready = 0;
   endtask

   task automatic test_simultaneous();
      ent_t exp0, exp1;
      exp0 = make_entry(1, 1'b0, 4'd3, 32'd9);
      exp1 = make_entry(1, 1'b1, 4'd1, 32'd4);
      do_clear_arm();
      step();                                                   // stamp 0
      reg_we = 1; reg_wnum = 2'd3; reg_wdata = 32'd9;
      mem_we = 1; mem_addr = 2'd1; mem_wdata = 32'd4; step();  // stamp 1
      reg_we = 0; mem_we = 0; freeze = 1; step();              // stamp 2
      freeze = 0;
      checks++;
      if (cnt0 !== 5'd2 || dat_o[0] !== exp0 || last_o[0] !== 1'b0) begin
         errors++; $display("FAIL simul_first: count=%0d data=%h last=%b need 2 %h 0", cnt0, dat_o[0], last_o[0], exp0);
      end
      rd_ready = 1; step();
      checks++;
      if (dat_o[0] !== exp1 || last_o[0] !== 1'b1) begin
         errors++; $display("FAIL simul_second: data=%h last=%b need %h 1", dat_o[0], last_o[0], exp1);
      end
      $display("txn simultaneous read %h", dat_o[0]);
      rd_ready = 0;
   endtask

   // Six reg writes: the stop-when-full ring keeps 1..4, the wrapping one keeps 3..6.
   task automatic test_full();
      do_clear_arm();
      reg_we = 1; reg_wnum = 2'd0;
      for (int k = 1; k <= 6; k++) begin
         reg_wdata = 32'(k); step();
      end
      reg_we = 0; freeze = 1; step(); freeze = 0;
      checks++;
      if (cnt1 !== 3'd4 || lost_o[1] !== 1'b1 || cnt2 !== 3'd4 || lost_o[2] !== 1'b1) begin
         errors++; $display("FAIL full_flags: stop count=%0d lost=%b wrap count=%0d lost=%b need 4 1 4 1",
                            cnt1, lost_o[1], cnt2, lost_o[2]);
      end
      checks++;
      if (cnt0 !== 5'd6 || lost_o[0] !== 1'b0) begin
         errors++; $display("FAIL full_deep: count=%0d lost=%b need 6 0", cnt0, lost_o[0]);
      end
      rd_ready = 1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (dat_o[1] !== make_entry(j, 1'b0, 4'd0, 32'(j + 1)) || last_o[1] !== (j == 3)) begin
            errors++; $display("FAIL full_stop_read%0d: data=%h last=%b need data %0d", j, dat_o[1], last_o[1], j + 1);
         end
         checks++;
         if (dat_o[2] !== make_entry(j + 2, 1'b0, 4'd0, 32'(j + 3)) || last_o[2] !== (j == 3)) begin
            errors++; $display("FAIL full_wrap_read%0d: data=%h last=%b need data %0d", j, dat_o[2], last_o[2], j + 3);
         end
         $display("txn full read stop=%0d wrap=%0d", dat_o[1][31:0], dat_o[2][31:0]);
         step();
      end
      checks++;
      if (vld_o[1] !== 1'b0 || vld_o[2] !== 1'b0) begin
         errors++; $display("FAIL full_drained: valid stop=%b wrap=%b need 0 0", vld_o[1], vld_o[2]);
      end
      rd_ready = 0;
   endtask

   // Both strobes with exactly one free slot.
   task automatic test_one_slot();
      ent_t e1 [4];
      ent_t e2 [4];
      e1[0] = make_entry(0, 1'b0, 4'd0, 32'd1);
      e1[1] = make_entry(1, 1'b0, 4'd0, 32'd2);
      e1[2] = make_entry(2, 1'b0, 4'd0, 32'd3);
      e1[3] = make_entry(3, 1'b0, 4'd2, 32'd4);
      e2[0] = e1[1]; e2[1] = e1[2]; e2[2] = e1[3];
      e2[3] = make_entry(3, 1'b1, 4'd3, 32'd8);
      do_clear_arm();
      reg_we = 1; reg_wnum = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         reg_wdata = 32'(k); step();
      end
      reg_wnum = 2'd2; reg_wdata = 32'd4;
      mem_we = 1; mem_addr = 2'd3; mem_wdata = 32'd8; freeze = 1; step();
      idle_inputs();
      checks++;
      if (cnt1 !== 3'd4 || lost_o[1] !== 1'b1 || st_o[1] !== 2'd2) begin
         errors++; $display("FAIL slot_flags: count=%0d lost=%b state=%0d need 4 1 2", cnt1, lost_o[1], st_o[1]);
      end
      rd_ready = 1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (dat_o[1] !== e1[j] || dat_o[2] !== e2[j]) begin
            errors++; $display("FAIL slot_read%0d: stop=%h wrap=%h need %h %h", j, dat_o[1], dat_o[2], e1[j], e2[j]);
         end
         step();
      end
      rd_ready = 0;
   endtask

   task automatic test_limit();
      ent_t head;
      head = make_entry(0, 1'b0, 4'd0, 32'd100);
      do_clear_arm();
      reg_we = 1; reg_wnum = 2'd0;
      for (int s = 0; s < 14; s++) begin
         reg_wdata = 32'(100 + s); step();
         if (s == 12) begin
            checks++;
            if (st_o[0] !== 2'd1) begin
               errors++; $display("FAIL limit_early: state=%0d after stamp 12, need 1", st_o[0]);
            end
         end
      end
      reg_we = 0;
      checks++;
      if (st_o[0] !== 2'd2 || lim_o[0] !== 1'b1 || cnt0 !== 5'd14) begin
         errors++; $display("FAIL limit_freeze: state=%0d lim=%b count=%0d need 2 1 14", st_o[0], lim_o[0], cnt0);
      end
      for (int h = 0; h < 5; h++) begin
         step();
         checks++;
         if (dat_o[0] !== head || cnt0 !== 5'd14 || vld_o[0] !== 1'b1) begin
            errors++; $display("FAIL limit_hold%0d: data=%h count=%0d valid=%b need %h 14 1", h, dat_o[0], cnt0, vld_o[0], head);
         end
      end
      clear = 1; step(); clear = 0;
      checks++;
      if (st_o[0] !== 2'd0 || lim_o[0] !== 1'b0 || cnt0 !== 5'd0) begin
         errors++; $display("FAIL limit_clear: state=%0d lim=%b count=%0d need 0 0 0", st_o[0], lim_o[0], cnt0);
      end
      // Freeze in the same cycle as the limit still records limit_hit.
      arm = 1; step(); arm = 0;
      for (int s = 0; s < 14; s++) begin
         freeze = (s == 13); step();
      end
      freeze = 0;
      checks++;
      if (st_o[0] !== 2'd2 || lim_o[0] !== 1'b1 || st_o[1] !== 2'd2 || lim_o[1] !== 1'b0) begin
         errors++; $display("FAIL limit_and_freeze: state0=%0d lim0=%b state1=%0d lim1=%b need 2 1 2 0",
                            st_o[0], lim_o[0], st_o[1], lim_o[1]);
      end
      $display("txn limit scenario done");
   endtask

   task automatic test_random();
      bit   ev;
      ent_t ed;
      idle_inputs();
      clear = 1; step(); clear = 0;
      for (int c = 0; c < 1500; c++) begin
         clear    = ($urandom_range(0, 99) < 3);
         arm      = ($urandom_range(0, 99) < 25);
         freeze   = ($urandom_range(0, 99) < 6);
         reg_we   = 1'($urandom_range(0, 1));
         mem_we   = 1'($urandom_range(0, 1));
         rd_ready = 1'($urandom_range(0, 1));
         reg_wnum = 2'($urandom); mem_addr = 2'($urandom);
         reg_wdata = $urandom; mem_wdata = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 0;
            #1 model_reset();
            rst = 1;
         end
         step();
         for (int i = 0; i < NI; i++) begin
            ev = (mst[i] == 2) && (mcnt[i] > 0);
            ed = ev ? mbuf[i][0] : '0;
            checks++;
            if (st_o[i] !== 2'(mst[i]) || got_cnt(i) != mcnt[i]) begin
               errors++; $display("FAIL rnd_state cyc%0d inst%0d: state=%0d count=%0d need %0d %0d",
                                  c, i, st_o[i], got_cnt(i), mst[i], mcnt[i]);
            end
            checks++;
            if (vld_o[i] !== ev || dat_o[i] !== ed || last_o[i] !== (ev && mcnt[i] == 1)) begin
               errors++; $display("FAIL rnd_read cyc%0d inst%0d: valid=%b data=%h last=%b need %b %h %b",
                                  c, i, vld_o[i], dat_o[i], last_o[i], ev, ed, ev && mcnt[i] == 1);
            end
            checks++;
            if (lost_o[i] !== mlost[i] || lim_o[i] !== mlim[i]) begin
               errors++; $display("FAIL rnd_flags cyc%0d inst%0d: lost=%b lim=%b need %b %b",
                                  c, i, lost_o[i], lim_o[i], mlost[i], mlim[i]);
            end
         end
      end
      idle_inputs();
      $display("txn random run done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_simultaneous();
      test_full();
      test_one_slot();
      test_limit();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesisable debug trace recorder for the cpu. It snoops the register-file and data-memory write ports and timestamps every write. Writes are stored in a parametrised ring buffer until the buffer freezes on command or on a cycle limit. Contents are then streamed out oldest-first over a valid/ready port, so register and memory activity can be checked in hardware and by benches without hierarchical probing.

Parameters:
WIDTH, 32, data width of register/memory write data
RNUM_W, 2, register index width
AW, 2, memory address width
IDX_W, 4, entry index field width; must be >= RNUM_W and >= AW
CNT_W, 16, cycle-stamp width
DEPTH, 16, entries; power of two, >= 2
WRAP, 0, 0 = stop-when-full, 1 = circular overwrite of oldest
CYCLE_LIMIT, 14, auto-freeze after this many capture cycles; 0 disables

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
arm  in  1  IDLE -> CAPTURE
freeze  in  1  CAPTURE -> FROZEN
clear  in  1  synchronous return to IDLE, empties buffer
reg_we  in  1  register write strobe
reg_wnum  in  RNUM_W  register index
reg_wdata  in  WIDTH  register data
mem_we  in  1  memory write strobe
mem_addr  in  AW  memory address
mem_wdata  in  WIDTH  memory data
rd_valid  out  1  entry available
rd_ready  in  1  consumer accepts
rd_data  out  CNT_W+1+IDX_W+WIDTH  {stamp, kind, index zero-extended, data}
rd_last  out  1  current entry is final one
count  out  $clog2(DEPTH)+1  entries held
state  out  2  IDLE=0, CAPTURE=1, FROZEN=2
lost  out  1  sticky: at least one event not retained
limit_hit  out  1  sticky: freeze caused by CYCLE_LIMIT

Behaviour:
- Reset values (rst low): state=IDLE, count=0, pointers=0, stamp=0, lost=0, limit_hit=0, rd_valid=0, rd_last=0, rd_data=0.
- clear has priority over all other controls in every state: next state IDLE, count=0, pointers=0, lost=0, limit_hit=0.
- IDLE: strobes ignored. arm -> CAPTURE next edge with stamp=0.
- CAPTURE: stamp increments each cycle and saturates at all-ones.
- Each cycle, reg_we writes entry {stamp, kind=0, reg_wnum, reg_wdata}. mem_we writes {stamp, kind=1, mem_addr, mem_wdata}.
- Both strobes in one cycle: two entries with the same stamp, reg entry first. The ring uses up to 2 writes/cycle (wr_ptr, wr_ptr+1).
- The cycle in which freeze is asserted is still captured; FROZEN is entered on that edge.
- CYCLE_LIMIT!=0: the capture cycle with stamp==CYCLE_LIMIT-1 is the last one captured. FROZEN on that edge, limit_hit=1. If freeze is asserted in the same cycle, limit_hit is still set.
- Full, WRAP=0: excess entries dropped and lost=1. With one free slot and both strobes, the reg entry is kept and the mem entry dropped.
- Full, WRAP=1: new entries overwrite the oldest, the read pointer advances, count stays at DEPTH, lost=1.
- FROZEN:
  - strobes ignored.
  - rd_valid = (count!=0). rd_data = oldest entry. rd_last = (count==1).
  - Transfer on rd_valid & rd_ready: read pointer +1, count -1.
  - rd_data stays stable while rd_valid & !rd_ready.
  - After drain, remains FROZEN with rd_valid=0 until clear.
- arm outside IDLE and freeze outside CAPTURE: no effect.
- rst asserted mid-capture or mid-readout: immediate return to reset values; buffer contents are discarded.
- Pointer arithmetic wraps modulo DEPTH.
- count never exceeds DEPTH.

Decomposition:
- Package cpu_trace_pkg: state encoding (IDLE/CAPTURE/FROZEN), kind constants (KIND_REG=0, KIND_MEM=1), entry field offset/width functions.
- One sub-module, trace_ring: DEPTH x entry storage with dual write and single read, plus pointers and count. The FSM, stamp counter and flag logic stay in the top module.

Test Plan:
- Reset mid-capture: arm, 3 reg writes, pull rst low -> state=0, count=0, rd_valid=0, lost=0 asynchronously, before the next edge.
- Basic: arm; r1=5 at stamp 0; r2=7 at stamp 2; freeze at stamp 3 -> readout {0,0,1,5} then {2,0,2,7} with rd_last on the second; then rd_valid=0; state=2.
- Simultaneous: at stamp 1, reg r3=9 and mem a1=4 -> entries {1,0,3,9} then {1,1,1,4}; count=2.
- WRAP=0, DEPTH=4: reg writes of data 1..5 on consecutive cycles -> count=4, lost=1, readout data 1,2,3,4.
- WRAP=1, DEPTH=4: reg writes of data 1..6 -> count=4, lost=1, readout data 3,4,5,6 oldest first.
- CYCLE_LIMIT=14, no freeze: state=2 after the stamp-13 cycle, limit_hit=1. Hold rd_ready=0 for 5 cycles -> rd_data unchanged, count unchanged. Then clear -> state=0, limit_hit=0.
